// File: rtl/apb_master_module.sv
// apb_master_module
//   APB requester placed in front of the matmul APB slave. Takes one command
//   at a time on a valid/ready port, runs the APB SETUP and ACCESS phases, and
//   returns read data plus error status on a valid/ready response port. Only
//   one transfer is ever in flight. Every output is driven from a register.
//
// Ports
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   cmd_valid_i / cmd_ready_o     command handshake
//   cmd_write_i, cmd_addr_i,
//   cmd_wdata_i, cmd_strb_i       command payload
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_rdata_o, rsp_err_o,
//   rsp_timeout_o                 response payload
//   psel_o, penable_o, pwrite_o,
//   paddr_o, pwdata_o, pstrb_o    APB requester outputs
//   pready_i, pslverr_i, prdata_i APB completer inputs
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a command, APB bus idle
// SETUP  | psel high, penable low, exactly one cycle
// ACCESS | psel and penable high, waiting for pready or the timeout
// RESP   | response presented, waiting for rsp_ready_i

module apb_master_module #(
    parameter int DATA_WIDTH     = 32,
    parameter int BUS_WIDTH      = 64,
    parameter int ADDR_WIDTH     = 32,
    parameter int STRB_WIDTH     = BUS_WIDTH / DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [BUS_WIDTH-1:0]  cmd_wdata_i,
    input  logic [STRB_WIDTH-1:0] cmd_strb_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [BUS_WIDTH-1:0]  rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_timeout_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [BUS_WIDTH-1:0]  pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic                  pslverr_i,
    input  logic [BUS_WIDTH-1:0]  prdata_i
);

    // Wait timer is a down-counter loaded with the allowance on ACCESS entry;
    // terminal count 1 on a not-ready edge means the allowance is used up.
    localparam int              CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_cmd_ready;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [BUS_WIDTH-1:0]  r_pwdata;
    logic [STRB_WIDTH-1:0] r_pstrb;
    logic                  r_rsp_valid;
    logic [BUS_WIDTH-1:0]  r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;
    logic [CNT_W-1:0]      r_wait_cnt;

    state_t                w_state_nxt;
    logic                  w_cmd_ready_nxt;
    logic                  w_psel_nxt;
    logic                  w_penable_nxt;
    logic                  w_pwrite_nxt;
    logic [ADDR_WIDTH-1:0] w_paddr_nxt;
    logic [BUS_WIDTH-1:0]  w_pwdata_nxt;
    logic [STRB_WIDTH-1:0] w_pstrb_nxt;
    logic                  w_rsp_valid_nxt;
    logic [BUS_WIDTH-1:0]  w_rsp_rdata_nxt;
    logic                  w_rsp_err_nxt;
    logic                  w_rsp_timeout_nxt;
    logic [CNT_W-1:0]      w_wait_cnt_nxt;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_cmd_ready   <= 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pstrb       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_cmd_ready   <= w_cmd_ready_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_pstrb       <= w_pstrb_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cmd_ready_nxt   = r_cmd_ready;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_pwrite_nxt      = r_pwrite;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_pstrb_nxt       = r_pstrb;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_wait_cnt_nxt    = r_wait_cnt;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid_i && r_cmd_ready) begin
                    w_cmd_ready_nxt = 1'b0;
                    w_psel_nxt      = 1'b1;
                    w_pwrite_nxt    = cmd_write_i;
                    w_paddr_nxt     = cmd_addr_i;
                    w_pwdata_nxt    = cmd_wdata_i;
                    // Strobes carry no meaning on a read, so never drive them.
                    w_pstrb_nxt     = cmd_write_i ? cmd_strb_i : '0;
                    w_state_nxt     = S_SETUP;
                end
            end

            S_SETUP: begin
                w_penable_nxt  = 1'b1;
                w_wait_cnt_nxt = CNT_LOAD;
                w_state_nxt    = S_ACCESS;
            end

            S_ACCESS: begin
                // pready wins over an expiring timer on the same edge.
                if (pready_i) begin
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = pslverr_i;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_rdata_nxt   = (!r_pwrite && !pslverr_i) ? prdata_i : '0;
                    w_state_nxt       = S_RESP;
                end else if (TIMEOUT_EN && (r_wait_cnt == CNT_ONE)) begin
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_rdata_nxt   = '0;
                    w_state_nxt       = S_RESP;
                end else if (TIMEOUT_EN) begin
                    w_wait_cnt_nxt = r_wait_cnt - CNT_ONE;
                end
            end

            S_RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid_nxt   = 1'b0;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_err_nxt     = 1'b0;
                    w_rsp_timeout_nxt = 1'b0;
                    w_cmd_ready_nxt   = 1'b1;
                    w_state_nxt       = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign cmd_ready_o   = r_cmd_ready;
    assign psel_o        = r_psel;
    assign penable_o     = r_penable;
    assign pwrite_o      = r_pwrite;
    assign paddr_o       = r_paddr;
    assign pwdata_o      = r_pwdata;
    assign pstrb_o       = r_pstrb;
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_rdata_o   = r_rsp_rdata;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_timeout;

endmodule

// File: tb/tb_apb_master_module.sv
module tb_apb_master_module;

    localparam int TO = 4;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [1:0]  strb;
        int          waits;
        logic        err;
        logic [63:0] rdata;
    } txn_t;

    typedef struct {
        logic        err;
        logic        to;
        logic [63:0] rdata;
        int          acc_cyc;
        int          lat;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic        cmd_write_i;
    logic [31:0] cmd_addr_i;
    logic [63:0] cmd_wdata_i;
    logic [1:0]  cmd_strb_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [63:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        rsp_timeout_o;
    logic        psel_o;
    logic        penable_o;
    logic        pwrite_o;
    logic [31:0] paddr_o;
    logic [63:0] pwdata_o;
    logic [1:0]  pstrb_o;
    logic        pready_i;
    logic        pslverr_i;
    logic [63:0] prdata_i;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   force_hold = -1;
    txn_t slv_q[$];
    exp_t exp_q[$];

    apb_master_module #(
        .DATA_WIDTH(32), .BUS_WIDTH(64), .ADDR_WIDTH(32), .STRB_WIDTH(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_strb_i(cmd_strb_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .paddr_o(paddr_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
        .pready_i(pready_i), .pslverr_i(pslverr_i), .prdata_i(prdata_i)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_bound(input string name);
        n_checks++;
        $display("FAIL %s: actual=bound expired required=event seen (cycle %0d)", name, cyc);
    endtask

    // Reference rules: a transfer times out when its wait states reach the allowance.
    function automatic bit is_to(input int waits);
        return (TO != 0) && (waits >= TO);
    endfunction

    function automatic int access_cycles(input int waits);
        return is_to(waits) ? TO : waits + 1;
    endfunction

    function automatic exp_t model(input txn_t t, input int acc_cyc);
        exp_t e;
        e.to      = is_to(t.waits);
        e.err     = e.to ? 1'b1 : t.err;
        e.rdata   = (!t.wr && !e.err) ? t.rdata : 64'd0;
        e.acc_cyc = acc_cyc;
        e.lat     = 1 + access_cycles(t.waits);
        return e;
    endfunction

    task automatic send(input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                        input logic [1:0] st, input int waits, input logic err,
                        input logic [63:0] rd);
        txn_t t;
        int   guard;
        int   acc;
        t.wr = wr; t.addr = addr; t.wdata = wd; t.strb = st;
        t.waits = waits; t.err = err; t.rdata = rd;
        cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr;
        cmd_wdata_i = wd; cmd_strb_i = st;
        guard = 0;
        while (cmd_ready_o !== 1'b1 && guard < 300) begin
            @(negedge clk_i);
            guard++;
        end
        if (cmd_ready_o !== 1'b1) begin
            fail_bound("cmd_accept");
            cmd_valid_i = 1'b0;
            return;
        end
        acc = cyc + 1;
        @(posedge clk_i);
        slv_q.push_back(t);
        exp_q.push_back(model(t, acc));
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_write_i = 1'($urandom);
        cmd_addr_i  = $urandom;
        cmd_wdata_i = {$urandom, $urandom};
        cmd_strb_i  = 2'($urandom);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_q.size() > 0 || rsp_valid_o === 1'b1) && g < 500) begin
            @(negedge clk_i);
            g++;
        end
        if (g >= 500) fail_bound("drain");
    endtask

    // APB completer model: checks the request phases and answers after the
    // programmed number of wait states.
    initial begin
        txn_t cur;
        int   acc;
        bit   in_x;
        pready_i = 1'b0; pslverr_i = 1'b0; prdata_i = '0;
        in_x = 0; acc = 0;
        forever begin
            @(negedge clk_i);
            if (rst_ni !== 1'b1) begin
                pready_i = 1'b0;
                in_x = 0;
            end else if (psel_o === 1'b1 && penable_o === 1'b0) begin
                chk("setup_expected", slv_q.size() > 0, 1);
                if (slv_q.size() > 0) begin
                    cur = slv_q.pop_front();
                    in_x = 1; acc = 0;
                    chk("setup_paddr", paddr_o, cur.addr);
                    chk("setup_pwrite", pwrite_o, cur.wr);
                    chk("setup_pwdata", pwdata_o, cur.wdata);
                    chk("setup_pstrb", pstrb_o, cur.wr ? cur.strb : 2'b00);
                end
                pready_i = 1'b0;
                pslverr_i = 1'($urandom);
                prdata_i = {$urandom, $urandom};
            end else if (psel_o === 1'b1 && penable_o === 1'b1) begin
                if (in_x) begin
                    chk("access_paddr", paddr_o, cur.addr);
                    chk("access_pstrb", pstrb_o, cur.wr ? cur.strb : 2'b00);
                    chk("access_pwdata", pwdata_o, cur.wdata);
                end
                if (in_x && acc == cur.waits) begin
                    pready_i = 1'b1; pslverr_i = cur.err; prdata_i = cur.rdata;
                end else begin
                    pready_i = 1'b0; pslverr_i = 1'($urandom); prdata_i = {$urandom, $urandom};
                end
                acc++;
            end else begin
                if (in_x) begin
                    chk("access_cycles", acc, access_cycles(cur.waits));
                    in_x = 0;
                end
                pready_i = 1'b0;
                pslverr_i = 1'b0;
            end
        end
    end

    // Response monitor: pops the expected response when the DUT presents one.
    initial begin
        exp_t cur;
        bit   have;
        int   hold;
        rsp_ready_i = 1'b0; have = 0; hold = 0;
        forever begin
            @(negedge clk_i);
            if (rst_ni !== 1'b1) begin
                have = 0;
                rsp_ready_i = 1'b0;
            end else if (rsp_valid_o === 1'b1) begin
                if (!have) begin
                    chk("rsp_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        have = 1;
                        chk("rsp_latency", cyc - cur.acc_cyc, cur.lat);
                        hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 2));
                    end
                end
                if (have) begin
                    chk("rsp_err", rsp_err_o, cur.err);
                    chk("rsp_timeout", rsp_timeout_o, cur.to);
                    chk("rsp_rdata", rsp_rdata_o, cur.rdata);
                    chk("rsp_cmd_ready", cmd_ready_o, 0);
                    chk("rsp_psel", psel_o, 0);
                end
                if (hold > 0) begin
                    rsp_ready_i = 1'b0;
                    hold--;
                end else begin
                    rsp_ready_i = 1'b1;
                end
            end else begin
                have = 0;
                rsp_ready_i = 1'($urandom);
            end
        end
    end

    initial begin
        int g;
        rst_ni = 1'b0;
        cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0;
        cmd_wdata_i = '0; cmd_strb_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_cmd_ready", cmd_ready_o, 1);
        chk("reset_psel", psel_o, 0);
        chk("reset_penable", penable_o, 0);
        chk("reset_pwrite", pwrite_o, 0);
        chk("reset_paddr", paddr_o, 0);
        chk("reset_pwdata", pwdata_o, 0);
        chk("reset_pstrb", pstrb_o, 0);
        chk("reset_rsp_valid", rsp_valid_o, 0);
        chk("reset_rsp_rdata", rsp_rdata_o, 0);
        chk("reset_rsp_err", {rsp_err_o, rsp_timeout_o}, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        send(1'b1, 32'd1, 64'hDEADBEEF_01234567, 2'b11, 0, 1'b0, 64'h1111);
        drain();
        send(1'b0, 32'd2, 64'h0123, 2'b01, 3, 1'b0, 64'h5);
        drain();
        send(1'b0, 32'd3, 64'h0, 2'b10, 1, 1'b1, 64'hABCD);
        drain();
        force_hold = 5;
        send(1'b0, 32'd4, 64'h77, 2'b11, 100, 1'b0, 64'h99);
        drain();
        force_hold = -1;

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk_i);
            send(1'($urandom), $urandom, {$urandom, $urandom}, 2'($urandom),
                 int'($urandom_range(0, 6)), 1'($urandom), {$urandom, $urandom});
        end
        drain();

        send(1'b0, 32'h40, 64'h0, 2'b11, 10, 1'b0, 64'h1234);
        g = 0;
        while (penable_o !== 1'b1 && g < 20) begin
            @(negedge clk_i);
            g++;
        end
        chk("rst_reached_access", penable_o, 1);
        rst_ni = 1'b0;
        exp_q.delete();
        @(posedge clk_i);
        #1;
        chk("rst_mid_psel", psel_o, 0);
        chk("rst_mid_penable", penable_o, 0);
        chk("rst_mid_rsp_valid", rsp_valid_o, 0);
        chk("rst_mid_cmd_ready", cmd_ready_o, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            chk("rst_no_rsp", rsp_valid_o, 0);
        end
        send(1'b1, 32'h44, 64'hCAFE_F00D_1234_5678, 2'b01, 2, 1'b0, 64'h0);
        drain();
        send(1'b0, 32'h48, 64'h0, 2'b11, 0, 1'b0, 64'hFEED_BEEF_0000_0001);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
